// File: rtl/ref_row_server.sv
// Row store for the interpolator: loads one raster frame over valid/ready, then answers row requests.
// Latency: 1 cycle from req_valid to row_valid, no back-pressure; wr_ready drops while a frame is held.
module ref_row_server #(
  parameter int PIX_W    = 8,
  parameter int ROW_PIX  = 15,
  parameter int NUM_ROWS = 15,
  parameter int IDX_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [PIX_W-1:0]         wr_pixel,
  input  logic                     wr_last,
  output logic                     frame_loaded,
  output logic                     load_err,
  input  logic                     frame_release,
  input  logic                     req_valid,
  input  logic [IDX_W-1:0]         next_row,
  output logic [PIX_W*ROW_PIX-1:0] in_row,
  output logic                     row_valid,
  output logic                     row_err
);

  localparam int FRAME_PIX = NUM_ROWS * ROW_PIX;
  localparam int CNT_W     = $clog2(FRAME_PIX);
  localparam int ROW_W     = $clog2(NUM_ROWS);
  localparam int COL_W     = $clog2(ROW_PIX);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_PIX - 1);

  typedef enum logic {LOAD, SERVE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         pix_cnt;
  logic [ROW_W-1:0]         row_ptr;
  logic [COL_W-1:0]         col_ptr;
  logic [PIX_W-1:0]         store [NUM_ROWS][ROW_PIX];
  logic [PIX_W*ROW_PIX-1:0] row_dat;
  logic [ROW_W-1:0]         row_idx;
  logic                     accept;
  logic                     last_pix;
  logic                     row_hit;

  // A release in the same cycle as a beat discards that beat along with the partial frame.
  assign accept   = wr_valid && (state == LOAD) && !frame_release;
  assign last_pix = (pix_cnt == LAST_PIX);
  assign row_hit  = (next_row < IDX_W'(NUM_ROWS));
  assign row_idx  = next_row[ROW_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (frame_release)
          state_nxt = LOAD;
        else if (accept && last_pix)
          state_nxt = SERVE;
      end
      SERVE: begin
        if (frame_release)
          state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      pix_cnt      <= '0;
      row_ptr      <= '0;
      col_ptr      <= '0;
      wr_ready     <= 1'b1;
      frame_loaded <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ready     <= (state_nxt == LOAD);
      frame_loaded <= (state_nxt == SERVE);
      if (frame_release) begin
        pix_cnt  <= '0;
        row_ptr  <= '0;
        col_ptr  <= '0;
        load_err <= 1'b0;
      end else if (accept) begin
        pix_cnt <= pix_cnt + 1'b1;
        if (col_ptr == LAST_COL) begin
          col_ptr <= '0;
          row_ptr <= row_ptr + 1'b1;
        end else begin
          col_ptr <= col_ptr + 1'b1;
        end
        // Completion is by count; wr_last is only cross-checked against it.
        if (wr_last != last_pix)
          load_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept)
      store[row_ptr][col_ptr] <= wr_pixel;
  end

  always_comb begin
    row_dat = '0;
    for (int k = 0; k < ROW_PIX; k++)
      row_dat[k*PIX_W +: PIX_W] = store[row_idx][k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_row    <= '0;
      row_valid <= 1'b0;
      row_err   <= 1'b0;
    end else if (req_valid) begin
      row_valid <= 1'b1;
      if ((state == SERVE) && row_hit) begin
        in_row  <= row_dat;
        row_err <= 1'b0;
      end else begin
        in_row  <= '0;
        row_err <= 1'b1;
      end
    end else begin
      row_valid <= 1'b0;
      row_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ref_row_server.sv
// Randomized bench for ref_row_server against a flat frame-buffer reference model.
module tb_ref_row_server;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [7:0]   wr_pixel;
  logic         wr_last;
  logic         frame_loaded;
  logic         load_err;
  logic         frame_release;
  logic         req_valid;
  logic [7:0]   next_row;
  logic [119:0] in_row;
  logic         row_valid;
  logic         row_err;

  int checks = 0;
  int errors = 0;

  // reference model: frame kept as a flat list of 225 pixels
  logic [7:0]   m_mem [225];
  int           m_cnt;
  bit           m_loaded;
  bit           m_err;
  logic [119:0] m_in_row;
  bit           e_rv;
  bit           e_re;

  ref_row_server dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pixel(wr_pixel), .wr_last(wr_last),
    .frame_loaded(frame_loaded), .load_err(load_err), .frame_release(frame_release),
    .req_valid(req_valid), .next_row(next_row),
    .in_row(in_row), .row_valid(row_valid), .row_err(row_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [119:0] model_row(input int r);
    logic [119:0] v;
    for (int k = 0; k < 15; k++)
      v[k*8 +: 8] = m_mem[r*15 + k];
    return v;
  endfunction

  function automatic logic [7:0] pattern_pix(input int n);
    return 8'(((n / 15) * 16 + (n % 15)) & 255);
  endfunction

  // One clock: predict from the driven inputs, advance the model, compare every output.
  task automatic step();
    if (rst) begin
      e_rv = 0; e_re = 0; m_in_row = '0;
    end else begin
      e_rv = req_valid;
      e_re = req_valid && !(m_loaded && next_row < 15);
      if (req_valid)
        m_in_row = e_re ? 120'd0 : model_row(int'(next_row));
    end
    if (rst) begin
      m_loaded = 0; m_cnt = 0; m_err = 0;
    end else if (frame_release) begin
      m_loaded = 0; m_cnt = 0; m_err = 0;
    end else if (!m_loaded && wr_valid) begin
      m_mem[m_cnt] = wr_pixel;
      if (wr_last != (m_cnt == 224)) m_err = 1;
      m_cnt++;
      if (m_cnt == 225) m_loaded = 1;
    end
    @(posedge clk);
    #1;
    check("wr_ready", wr_ready, !m_loaded);
    check("frame_loaded", frame_loaded, m_loaded);
    check("load_err", load_err, m_err);
    check("row_valid", row_valid, e_rv);
    check("row_err", row_err, e_re);
    check("in_row", in_row, m_in_row);
  endtask

  task automatic idle_inputs();
    rst = 0; wr_valid = 0; wr_pixel = '0; wr_last = 0;
    frame_release = 0; req_valid = 0; next_row = '0;
  endtask

  task automatic req(input int row);
    idle_inputs();
    req_valid = 1;
    next_row  = 8'(row);
    step();
  endtask

  // Streams one frame with random gaps and random requests; rst_at < 0 and err_pos < 0 disable those events.
  task automatic load_frame(input bit use_pattern, input int err_pos, input bit final_last, input int rst_at);
    int  guard = 0;
    bit  rst_done = 0;
    while (!m_loaded && guard < 3000) begin
      guard++;
      idle_inputs();
      if (rst_at >= 0 && m_cnt == rst_at && !rst_done) begin
        rst = 1;
        rst_done = 1;
        step();
        idle_inputs();
        check("rst_mid_wr_ready", wr_ready, 1);
        check("rst_mid_frame_loaded", frame_loaded, 0);
      end else begin
        wr_valid = ($urandom_range(0, 3) != 0) || (m_cnt == 100);
        wr_pixel = use_pattern ? pattern_pix(m_cnt) : 8'($urandom);
        wr_last  = (m_cnt == err_pos) || (final_last && m_cnt == 224);
        if (m_cnt == 100) begin
          req_valid = 1;
          next_row  = 8'd2;
        end else begin
          req_valid = ($urandom_range(0, 4) == 0);
          next_row  = 8'($urandom);
        end
        step();
        if (next_row == 8'd2 && req_valid && m_cnt == 101) begin
          check("load_req_err", row_err, 1);
          check("load_req_row", in_row, 0);
        end
      end
    end
    if (guard >= 3000) check("load_timeout", 0, 1);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_cnt = 0; m_loaded = 0; m_err = 0; m_in_row = '0;
    rst = 1;
    step();
    step();
    check("reset_wr_ready", wr_ready, 1);

    // pattern frame, clean wr_last
    load_frame(1, -1, 1, -1);
    check("loaded_flag", frame_loaded, 1);
    check("loaded_no_err", load_err, 0);

    req(3);
    check("row3_p0", in_row[7:0], 8'h30);
    check("row3_p14", in_row[119:112], 8'h3E);
    req(0);
    check("row0_p0", in_row[7:0], 8'h00);
    req(14);
    check("row14_p0", in_row[7:0], 8'hE0);
    req(15);
    check("row15_err", row_err, 1);
    req(200);
    check("row200_err", row_err, 1);
    check("row200_zero", in_row, 0);

    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      req_valid = $urandom_range(0, 1);
      next_row  = 8'($urandom_range(0, 20));
      wr_valid  = $urandom_range(0, 1);
      wr_pixel  = 8'($urandom);
      step();
    end

    // release, then a frame with an early wr_last
    idle_inputs(); frame_release = 1; step();
    load_frame(0, 50, 1, -1);
    check("early_last_err", load_err, 1);
    idle_inputs(); frame_release = 1; step();
    check("release_clr_err", load_err, 0);
    check("release_wr_ready", wr_ready, 1);

    // reset in mid-load, then a fresh complete load
    load_frame(0, -1, 1, 120);
    check("fresh_no_err", load_err, 0);
    idle_inputs();
    req_valid = 1; next_row = 8'd7; frame_release = 1;
    step();
    check("rel_req_valid", row_valid, 1);
    check("rel_req_err", row_err, 0);
    check("rel_req_row7", in_row, model_row(7));
    check("rel_unloaded", frame_loaded, 0);
    idle_inputs(); step();

    // partial load released, then a frame missing its final wr_last
    for (int i = 0; i < 30; i++) begin
      idle_inputs(); wr_valid = 1; wr_pixel = 8'($urandom); step();
    end
    idle_inputs(); frame_release = 1; step();
    load_frame(0, -1, 0, -1);
    check("missing_last_err", load_err, 1);
    for (int i = 0; i < 20; i++) req($urandom_range(0, 16));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
